ex_stage_mdu: RTL and testbench
===============================

// Module: ex_stage_mdu
// PURPOSE
//  Parametrised execute stage with an iterative multiply/divide unit (MDU).
//  Sits between the ID/EX and EX/MEM registers and owns the EX/MEM register.
//  Single-cycle ALU ops complete in one clock. MUL/DIVU/REMU hold the pipe via stall_o.
//  Operand forwarding from MEM and WB is selected by the external forwarding unit.
// PARAMETERS
//  XLEN    32  datapath width; >=8, power of two
//  REG_AW  5   register-address width
//  MDU_EN  1   1: MDU present; 0: MDU functs decode as unknown (result 0, no stall)
// PORTS
//  clk_i              in   1       clock, rising edge
//  start_i            in   1       asynchronous active-low reset
//  RegWrite_i         in   1       ID/EX control, passed through
//  MemToReg_i         in   1       ID/EX control, passed through
//  MemRead_i          in   2       ID/EX control, passed through
//  MemWrite_i         in   2       ID/EX control, passed through
//  ALUOp_i            in   2       0 none/bubble, 1 R-type, 2 addi, 3 lw/sw (add)
//  ALUSrc_i           in   1       1: operand B = ExtImmd_i; 0: operand B = forwarded RT
//  RegDst_i           in   1       1: dest = RDaddr_i; 0: dest = RTaddr_i
//  RTaddr_i           in   REG_AW  rt address
//  RDaddr_i           in   REG_AW  rd address
//  Funct_i            in   6       R-type function field
//  RSdata_i           in   XLEN    rs register-file data
//  RTdata_i           in   XLEN    rt register-file data
//  ExtImmd_i          in   XLEN    sign-extended immediate
//  RSdatasrc_i        in   2       rs select: 0 reg, 1 WB, 2 MEM, 3 zero
//  RTdatasrc_i        in   2       rt select, same encoding as RSdatasrc_i
//  MEM_ALU_result_i   in   XLEN    EX/MEM ALU result, forwarding source
//  WB_RegData_i       in   XLEN    write-back data, forwarding source
//  RegWrite_o         out  1       EX/MEM control
//  MemToReg_o         out  1       EX/MEM control
//  MemRead_o          out  2       EX/MEM control
//  MemWrite_o         out  2       EX/MEM control
//  RegAddr_o          out  REG_AW  write-back register address
//  WriteData_o        out  XLEN    forwarded rt, used as store data
//  ALUdata_o          out  XLEN    result / memory address
//  stall_o            out  1       1: upstream holds PC, IF/ID and ID/EX this cycle
// BEHAVIOUR
//  - Reset (start_i low, async): all registered outputs 0, FSM to IDLE, counter 0.
//    Reset mid-MDU abandons the operation and leaves no residue.
//  - Funct decode, ALUOp=1: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed),
//    0x18 MUL (low XLEN bits of product), 0x1B DIVU (quotient), 0x1F REMU (remainder).
//    Unknown funct gives result 0. ALUOp 2/3 add; ALUOp 0 gives result 0.
//  - All arithmetic is modulo 2^XLEN; no overflow traps.
//  - Non-MDU op: EX/MEM register loads all outputs on the next rising edge (1-cycle latency).
//  - FSM states: IDLE, MUL, DIV, DONE.
//    IDLE: an MDU op at the input asserts stall_o combinationally in the same cycle.
//      That edge captures both forwarded operands and the op, then moves to MUL or DIV.
//      The counter loads XLEN-1. The EX/MEM register loads a bubble (all controls 0).
//    MUL/DIV: one shift-add or restoring-subtract step per cycle; the counter decrements.
//      At counter 0 the FSM moves to DONE. stall_o=1 throughout and EX/MEM loads bubbles.
//    DONE: stall_o=0. EX/MEM loads the MDU result with the held control/address inputs.
//      Next state is IDLE. A new MDU op is never started from DONE.
//  - MDU op occupancy: XLEN+2 cycles (accept, XLEN steps, DONE). Result is visible the cycle after DONE.
//  - Operands are captured at accept, so forwarding-source changes during stall are ignored.
//  - WriteData_o/RegAddr_o in DONE come from the current (held) inputs.
//  - Divide by zero: quotient all-ones, remainder = dividend, same latency.
//  - Upstream contract: all *_i inputs stay stable while stall_o=1. Forwarding selects during
//    DONE refer to the held instruction.
// TESTING
//  - ALUOp=1, funct 0x22, RS=10 (select 0), RT forwarded from MEM=3 (select 2)
//    -> ALUdata_o=7 next edge, stall_o never 1.
//  - MUL 7*6 -> stall_o high 33 cycles, then ALUdata_o=42, RegWrite_o=1 on edge 34;
//    bubbles (RegWrite_o=0) on edges 1..33.
//  - DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF; each with 34-cycle occupancy.
//  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
//  - Pull start_i low at cycle 10 of a MUL -> all outputs 0 and stall_o=0 immediately.
//    A new add after release completes in 1 cycle.
//  - MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE; with MDU_EN=0 the same op gives 0 and no stall.

Source files
------------

// File: rtl/ex_stage_mdu.sv
// Execute stage: operand forwarding, single-cycle ALU, EX/MEM pipeline register,
// and an iterative shift-add / restoring-divide unit that holds the front end.
module ex_stage_mdu #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter bit MDU_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              start_i,
    input  logic              RegWrite_i,
    input  logic              MemToReg_i,
    input  logic [1:0]        MemRead_i,
    input  logic [1:0]        MemWrite_i,
    input  logic [1:0]        ALUOp_i,
    input  logic              ALUSrc_i,
    input  logic              RegDst_i,
    input  logic [REG_AW-1:0] RTaddr_i,
    input  logic [REG_AW-1:0] RDaddr_i,
    input  logic [5:0]        Funct_i,
    input  logic [XLEN-1:0]   RSdata_i,
    input  logic [XLEN-1:0]   RTdata_i,
    input  logic [XLEN-1:0]   ExtImmd_i,
    input  logic [1:0]        RSdatasrc_i,
    input  logic [1:0]        RTdatasrc_i,
    input  logic [XLEN-1:0]   MEM_ALU_result_i,
    input  logic [XLEN-1:0]   WB_RegData_i,
    output logic              RegWrite_o,
    output logic              MemToReg_o,
    output logic [1:0]        MemRead_o,
    output logic [1:0]        MemWrite_o,
    output logic [REG_AW-1:0] RegAddr_o,
    output logic [XLEN-1:0]   WriteData_o,
    output logic [XLEN-1:0]   ALUdata_o,
    output logic              stall_o
);
    localparam int CW = $clog2(XLEN);

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_MUL  = 6'h18;
    localparam logic [5:0] FN_DIVU = 6'h1B;
    localparam logic [5:0] FN_REMU = 6'h1F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_reg;
    state_t state_next;

    // ------------------------------------------------------------------
    // Operand forwarding: index 0 is rs, index 1 is rt
    // ------------------------------------------------------------------
    logic [XLEN-1:0] regData [2];
    logic [1:0]      fwdSel  [2];
    logic [XLEN-1:0] fwdData [2];

    assign regData[0] = RSdata_i;
    assign regData[1] = RTdata_i;
    assign fwdSel[0]  = RSdatasrc_i;
    assign fwdSel[1]  = RTdatasrc_i;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwdData[gi] = (fwdSel[gi] == 2'd0) ? regData[gi]      :
                                 (fwdSel[gi] == 2'd1) ? WB_RegData_i     :
                                 (fwdSel[gi] == 2'd2) ? MEM_ALU_result_i :
                                                        '0;
        end
    endgenerate

    logic [XLEN-1:0] opA;
    logic [XLEN-1:0] rtFwd;
    logic [XLEN-1:0] opB;

    assign opA   = fwdData[0];
    assign rtFwd = fwdData[1];
    assign opB   = ALUSrc_i ? ExtImmd_i : rtFwd;

    // ------------------------------------------------------------------
    // Decode and single-cycle ALU
    // ------------------------------------------------------------------
    logic isMduFunct;
    logic mduReq;
    logic sltBit;
    logic [XLEN-1:0] aluResult;

    assign isMduFunct = (Funct_i == FN_MUL) || (Funct_i == FN_DIVU) || (Funct_i == FN_REMU);
    assign mduReq     = MDU_EN && (ALUOp_i == 2'd1) && isMduFunct;
    assign sltBit     = $signed(opA) < $signed(opB);

    always_comb begin
        aluResult = '0;
        case (ALUOp_i)
            2'd1: begin
                case (Funct_i)
                    FN_ADD:  aluResult = opA + opB;
                    FN_SUB:  aluResult = opA - opB;
                    FN_AND:  aluResult = opA & opB;
                    FN_OR:   aluResult = opA | opB;
                    FN_SLT:  aluResult = {{(XLEN-1){1'b0}}, sltBit};
                    default: aluResult = '0;
                endcase
            end
            2'd2, 2'd3: aluResult = opA + opB;
            default:    aluResult = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // MDU control FSM
    // ------------------------------------------------------------------
    logic [CW-1:0] count_reg;
    logic          stallRaw;
    logic          mduLoad;
    logic          bubble;
    logic          mduDone;

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        stallRaw   = 1'b0;
        mduLoad    = 1'b0;
        bubble     = 1'b0;
        mduDone    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mduReq) begin
                    stallRaw   = 1'b1;
                    mduLoad    = 1'b1;
                    bubble     = 1'b1;
                    state_next = (Funct_i == FN_MUL) ? MUL : DIV;
                end
            end
            MUL, DIV: begin
                stallRaw = 1'b1;
                bubble   = 1'b1;
                if (count_reg == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                mduDone    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A held MDU instruction must not raise stall while the stage is in reset.
    assign stall_o = start_i & stallRaw;

    // ------------------------------------------------------------------
    // MDU datapath: accum holds product (MUL) or partial remainder (DIV);
    // shiftA holds multiplicand or dividend/quotient; shiftB multiplier or divisor.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] accum_reg;
    logic [XLEN-1:0] shiftA_reg;
    logic [XLEN-1:0] shiftB_reg;
    logic            wantQuot_reg;

    logic [XLEN:0]   remShift;
    logic [XLEN:0]   remDiff;
    logic            divGe;
    logic [XLEN-1:0] mduResult;

    assign remShift  = {accum_reg, shiftA_reg[XLEN-1]};
    assign remDiff   = remShift - {1'b0, shiftB_reg};
    // Partial remainder is always below 2^XLEN, so the top bit is exactly the borrow.
    assign divGe     = ~remDiff[XLEN];
    assign mduResult = wantQuot_reg ? shiftA_reg : accum_reg;

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            count_reg    <= '0;
            accum_reg    <= '0;
            shiftA_reg   <= '0;
            shiftB_reg   <= '0;
            wantQuot_reg <= 1'b0;
        end else if (mduLoad) begin
            count_reg    <= CW'(XLEN - 1);
            accum_reg    <= '0;
            shiftA_reg   <= opA;
            shiftB_reg   <= opB;
            wantQuot_reg <= (Funct_i == FN_DIVU);
        end else if (state_reg == MUL) begin
            if (count_reg != '0) begin
                count_reg <= count_reg - 1'b1;
            end
            accum_reg  <= accum_reg + (shiftB_reg[0] ? shiftA_reg : '0);
            shiftA_reg <= shiftA_reg << 1;
            shiftB_reg <= shiftB_reg >> 1;
        end else if (state_reg == DIV) begin
            if (count_reg != '0) begin
                count_reg <= count_reg - 1'b1;
            end
            accum_reg  <= divGe ? remDiff[XLEN-1:0] : remShift[XLEN-1:0];
            shiftA_reg <= {shiftA_reg[XLEN-2:0], divGe};
        end
    end

    // ------------------------------------------------------------------
    // EX/MEM register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            RegWrite_o  <= 1'b0;
            MemToReg_o  <= 1'b0;
            MemRead_o   <= '0;
            MemWrite_o  <= '0;
            RegAddr_o   <= '0;
            WriteData_o <= '0;
            ALUdata_o   <= '0;
        end else if (bubble) begin
            RegWrite_o  <= 1'b0;
            MemToReg_o  <= 1'b0;
            MemRead_o   <= '0;
            MemWrite_o  <= '0;
            RegAddr_o   <= '0;
            WriteData_o <= '0;
            ALUdata_o   <= '0;
        end else begin
            RegWrite_o  <= RegWrite_i;
            MemToReg_o  <= MemToReg_i;
            MemRead_o   <= MemRead_i;
            MemWrite_o  <= MemWrite_i;
            RegAddr_o   <= RegDst_i ? RDaddr_i : RTaddr_i;
            WriteData_o <= rtFwd;
            ALUdata_o   <= mduDone ? mduResult : aluResult;
        end
    end

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Randomised and directed bench for ex_stage_mdu, checked every cycle against a
// transaction-level model (plain arithmetic plus an occupancy count per MDU op).
module tb_ex_stage_mdu;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NTXN = 160;

    logic            clk_i = 1'b0;
    logic            start_i = 1'b0;
    logic            RegWrite_i, MemToReg_i, ALUSrc_i, RegDst_i;
    logic [1:0]      MemRead_i, MemWrite_i, ALUOp_i, RSdatasrc_i, RTdatasrc_i;
    logic [AW-1:0]   RTaddr_i, RDaddr_i;
    logic [5:0]      Funct_i;
    logic [XLEN-1:0] RSdata_i, RTdata_i, ExtImmd_i, MEM_ALU_result_i, WB_RegData_i;

    logic            mRegWrite, mMemToReg, mStall;
    logic [1:0]      mMemRead, mMemWrite;
    logic [AW-1:0]   mRegAddr;
    logic [XLEN-1:0] mWriteData, mALUdata;
    logic            nRegWrite, nMemToReg, nStall;
    logic [1:0]      nMemRead, nMemWrite;
    logic [AW-1:0]   nRegAddr;
    logic [XLEN-1:0] nWriteData, nALUdata;

    always #5 clk_i = ~clk_i;

    ex_stage_mdu #(.XLEN(XLEN), .REG_AW(AW), .MDU_EN(1'b1)) dut (
        .clk_i(clk_i), .start_i(start_i),
        .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i), .RegDst_i(RegDst_i),
        .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i), .Funct_i(Funct_i),
        .RSdata_i(RSdata_i), .RTdata_i(RTdata_i), .ExtImmd_i(ExtImmd_i),
        .RSdatasrc_i(RSdatasrc_i), .RTdatasrc_i(RTdatasrc_i),
        .MEM_ALU_result_i(MEM_ALU_result_i), .WB_RegData_i(WB_RegData_i),
        .RegWrite_o(mRegWrite), .MemToReg_o(mMemToReg), .MemRead_o(mMemRead),
        .MemWrite_o(mMemWrite), .RegAddr_o(mRegAddr), .WriteData_o(mWriteData),
        .ALUdata_o(mALUdata), .stall_o(mStall)
    );

    ex_stage_mdu #(.XLEN(XLEN), .REG_AW(AW), .MDU_EN(1'b0)) dutNoMdu (
        .clk_i(clk_i), .start_i(start_i),
        .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i), .RegDst_i(RegDst_i),
        .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i), .Funct_i(Funct_i),
        .RSdata_i(RSdata_i), .RTdata_i(RTdata_i), .ExtImmd_i(ExtImmd_i),
        .RSdatasrc_i(RSdatasrc_i), .RTdatasrc_i(RTdatasrc_i),
        .MEM_ALU_result_i(MEM_ALU_result_i), .WB_RegData_i(WB_RegData_i),
        .RegWrite_o(nRegWrite), .MemToReg_o(nMemToReg), .MemRead_o(nMemRead),
        .MemWrite_o(nMemWrite), .RegAddr_o(nRegAddr), .WriteData_o(nWriteData),
        .ALUdata_o(nALUdata), .stall_o(nStall)
    );

    typedef struct packed {
        logic            regWrite;
        logic            memToReg;
        logic [1:0]      memRead;
        logic [1:0]      memWrite;
        logic [AW-1:0]   regAddr;
        logic [XLEN-1:0] writeData;
        logic [XLEN-1:0] aluData;
    } exOut_t;

    exOut_t actMain, actNo;
    assign actMain = {mRegWrite, mMemToReg, mMemRead, mMemWrite, mRegAddr, mWriteData, mALUdata};
    assign actNo   = {nRegWrite, nMemToReg, nMemRead, nMemWrite, nRegAddr, nWriteData, nALUdata};

    int compared   = 0;
    int mismatched = 0;

    // ---------------- reference model ----------------
    int              mduLeft   = 0;
    logic [XLEN-1:0] mduRes    = '0;
    exOut_t          expMain   = '0;
    logic            expBubble = 1'b0;
    exOut_t          expNo     = '0;
    logic            lastStall, lastStallNo, lastExpStall;

    function automatic logic [XLEN-1:0] fwdVal(input logic [1:0] sel, input logic [XLEN-1:0] r);
        case (sel)
            2'd0:    return r;
            2'd1:    return WB_RegData_i;
            2'd2:    return MEM_ALU_result_i;
            default: return '0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] aluRef(input logic [1:0] op, input logic [5:0] fn,
                                               input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                               input bit mduEn);
        if (op == 2'd0) return '0;
        if (op != 2'd1) return a + b;
        case (fn)
            6'h20: return a + b;
            6'h22: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h18: return mduEn ? a * b : '0;
            6'h1B: return !mduEn ? '0 : (b == 0) ? '1 : a / b;
            6'h1F: return !mduEn ? '0 : (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] curA();
        return fwdVal(RSdatasrc_i, RSdata_i);
    endfunction

    function automatic logic [XLEN-1:0] curB();
        return ALUSrc_i ? ExtImmd_i : fwdVal(RTdatasrc_i, RTdata_i);
    endfunction

    function automatic logic isMduOp();
        return (ALUOp_i == 2'd1) && (Funct_i == 6'h18 || Funct_i == 6'h1B || Funct_i == 6'h1F);
    endfunction

    function automatic exOut_t normalOut(input bit mduEn, input logic useRes, input logic [XLEN-1:0] res);
        exOut_t o;
        o.regWrite  = RegWrite_i;
        o.memToReg  = MemToReg_i;
        o.memRead   = MemRead_i;
        o.memWrite  = MemWrite_i;
        o.regAddr   = RegDst_i ? RDaddr_i : RTaddr_i;
        o.writeData = fwdVal(RTdatasrc_i, RTdata_i);
        o.aluData   = useRes ? res : aluRef(ALUOp_i, Funct_i, curA(), curB(), mduEn);
        return o;
    endfunction

    function automatic logic modelStall();
        return start_i && (mduLeft > 1 || (mduLeft == 0 && isMduOp()));
    endfunction

    // Each MDU op occupies XLEN+2 cycles; its result is written on the edge that leaves DONE.
    always @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            mduLeft   <= 0;
            mduRes    <= '0;
            expMain   <= '0;
            expBubble <= 1'b0;
            expNo     <= '0;
        end else begin
            expNo <= normalOut(1'b0, 1'b0, '0);
            if (mduLeft == 0 && isMduOp()) begin
                mduRes    <= aluRef(ALUOp_i, Funct_i, curA(), curB(), 1'b1);
                mduLeft   <= XLEN + 1;
                expMain   <= '0;
                expBubble <= 1'b1;
            end else if (mduLeft > 1) begin
                mduLeft   <= mduLeft - 1;
                expMain   <= '0;
                expBubble <= 1'b1;
            end else if (mduLeft == 1) begin
                mduLeft   <= 0;
                expMain   <= normalOut(1'b1, 1'b1, mduRes);
                expBubble <= 1'b0;
            end else begin
                expMain   <= normalOut(1'b1, 1'b0, '0);
                expBubble <= 1'b0;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkOut(input string pfx, input exOut_t act, input exOut_t exp, input logic bub);
        check({pfx, ".RegWrite"}, 32'(act.regWrite), 32'(exp.regWrite));
        check({pfx, ".MemToReg"}, 32'(act.memToReg), 32'(exp.memToReg));
        check({pfx, ".MemRead"},  32'(act.memRead),  32'(exp.memRead));
        check({pfx, ".MemWrite"}, 32'(act.memWrite), 32'(exp.memWrite));
        if (!bub) begin
            check({pfx, ".RegAddr"},   32'(act.regAddr), 32'(exp.regAddr));
            check({pfx, ".WriteData"}, act.writeData,    exp.writeData);
            check({pfx, ".ALUdata"},   act.aluData,      exp.aluData);
        end
    endtask

    task automatic compareAll();
        logic es;
        es           = modelStall();
        lastStall    = mStall;
        lastStallNo  = nStall;
        lastExpStall = es;
        check("main.stall", 32'(mStall), 32'(es));
        checkOut("main", actMain, expMain, expBubble);
        check("nomdu.stall", 32'(nStall), 32'd0);
        checkOut("nomdu", actNo, expNo, 1'b0);
    endtask

    task automatic stepCycle();
        @(negedge clk_i);
        compareAll();
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- stimulus ----------------
    task automatic idleInputs();
        RegWrite_i = 0; MemToReg_i = 0; MemRead_i = 0; MemWrite_i = 0;
        ALUOp_i = 0; ALUSrc_i = 0; RegDst_i = 0; RTaddr_i = 0; RDaddr_i = 0; Funct_i = 0;
        RSdata_i = 0; RTdata_i = 0; ExtImmd_i = 0; RSdatasrc_i = 0; RTdatasrc_i = 0;
        MEM_ALU_result_i = 0; WB_RegData_i = 0;
    endtask

    task automatic setRtype(input logic [5:0] fn, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        idleInputs();
        ALUOp_i = 2'd1; Funct_i = fn; RSdata_i = a; RTdata_i = b;
        RegWrite_i = 1'b1; RegDst_i = 1'b1; RDaddr_i = 5'd9; RTaddr_i = 5'd3;
    endtask

    task automatic mduDirected(input string name, input logic [5:0] fn, input logic [XLEN-1:0] a,
                               input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input bit checkNo);
        int stallCnt, bubbleBad, noStall;
        setRtype(fn, a, b);
        stallCnt = 0; bubbleBad = 0; noStall = 0;
        for (int k = 1; k <= XLEN + 2; k++) begin
            stepCycle();
            if (lastStall) stallCnt++;
            if (lastStallNo) noStall++;
            if (k <= XLEN + 1 && mRegWrite) bubbleBad++;
        end
        $display("txn %s: a=%08h b=%08h result=%08h stalls=%0d", name, a, b, mALUdata, stallCnt);
        check({name, ".stallCycles"}, 32'(stallCnt), 32'(XLEN + 1));
        check({name, ".bubbleRegWrite"}, 32'(bubbleBad), 32'd0);
        check({name, ".result"}, mALUdata, exp);
        check({name, ".RegWrite"}, 32'(mRegWrite), 32'd1);
        if (checkNo) begin
            check({name, ".nomduResult"}, nALUdata, 32'd0);
            check({name, ".nomduStalls"}, 32'(noStall), 32'd0);
        end
    endtask

    function automatic logic [XLEN-1:0] randVal();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return XLEN'($urandom_range(0, 20));
            default: return XLEN'($urandom);
        endcase
    endfunction

    task automatic randomTxn();
        logic [5:0] fnTab [9];
        int sel;
        fnTab[0] = 6'h20; fnTab[1] = 6'h22; fnTab[2] = 6'h24; fnTab[3] = 6'h25; fnTab[4] = 6'h2A;
        fnTab[5] = 6'h18; fnTab[6] = 6'h1B; fnTab[7] = 6'h1F; fnTab[8] = 6'($urandom);
        sel = $urandom_range(0, 9);
        ALUOp_i     = (sel == 0) ? 2'd0 : (sel <= 6) ? 2'd1 : (sel <= 8) ? 2'd2 : 2'd3;
        Funct_i     = fnTab[$urandom_range(0, 8)];
        RegWrite_i  = 1'($urandom); MemToReg_i = 1'($urandom);
        MemRead_i   = 2'($urandom); MemWrite_i = 2'($urandom);
        ALUSrc_i    = ($urandom_range(0, 3) == 0); RegDst_i = 1'($urandom);
        RTaddr_i    = AW'($urandom); RDaddr_i = AW'($urandom);
        RSdata_i    = randVal(); RTdata_i = randVal(); ExtImmd_i = randVal();
        RSdatasrc_i = 2'($urandom); RTdatasrc_i = 2'($urandom);
        MEM_ALU_result_i = randVal(); WB_RegData_i = randVal();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idleInputs();
        start_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset.ALUdata", mALUdata, 32'd0);
        check("reset.RegWrite", 32'(mRegWrite), 32'd0);
        check("reset.stall", 32'(mStall), 32'd0);
        start_i = 1'b1;

        // SUB with rt forwarded from MEM
        idleInputs();
        ALUOp_i = 2'd1; Funct_i = 6'h22; RSdata_i = 32'd10; RTdata_i = 32'd99;
        RTdatasrc_i = 2'd2; MEM_ALU_result_i = 32'd3; RegWrite_i = 1'b1; RegDst_i = 1'b1; RDaddr_i = 5'd4;
        stepCycle();
        $display("txn sub: result=%08h", mALUdata);
        check("sub.stall", 32'(lastStall), 32'd0);
        check("sub.ALUdata", mALUdata, 32'd7);
        check("sub.RegAddr", 32'(mRegAddr), 32'd4);

        mduDirected("mul7x6",    6'h18, 32'd7,          32'd6, 32'd42,         1'b0);
        mduDirected("divu100_7", 6'h1B, 32'd100,        32'd7, 32'd14,         1'b0);
        mduDirected("remu100_7", 6'h1F, 32'd100,        32'd7, 32'd2,          1'b0);
        mduDirected("divuMax_1", 6'h1B, 32'hFFFF_FFFF,  32'd1, 32'hFFFF_FFFF,  1'b0);
        mduDirected("divu5_0",   6'h1B, 32'd5,          32'd0, 32'hFFFF_FFFF,  1'b0);
        mduDirected("remu5_0",   6'h1F, 32'd5,          32'd0, 32'd5,          1'b0);
        mduDirected("mulMax_2",  6'h18, 32'hFFFF_FFFF,  32'd2, 32'hFFFF_FFFE,  1'b1);

        // Reset in the middle of a MUL
        setRtype(6'h18, 32'h1234, 32'h55);
        for (int k = 0; k < 10; k++) stepCycle();
        start_i = 1'b0;
        #1;
        $display("txn reset-mid-mul: stall=%0b ALUdata=%08h", mStall, mALUdata);
        check("rstmid.stall", 32'(mStall), 32'd0);
        check("rstmid.ALUdata", mALUdata, 32'd0);
        check("rstmid.RegWrite", 32'(mRegWrite), 32'd0);
        check("rstmid.RegAddr", 32'(mRegAddr), 32'd0);
        stepCycle();
        stepCycle();
        setRtype(6'h20, 32'd1000, 32'd234);
        start_i = 1'b1;
        stepCycle();
        $display("txn add-after-reset: result=%08h", mALUdata);
        check("rstadd.stall", 32'(lastStall), 32'd0);
        check("rstadd.ALUdata", mALUdata, 32'd1234);

        // Randomised traffic; inputs held while the model says the stage is stalled
        for (int t = 0; t < NTXN; t++) begin
            int guard;
            randomTxn();
            $display("txn %0d: aluop=%0d funct=%02h rs=%08h rt=%08h imm=%08h src=%0d/%0d",
                     t, ALUOp_i, Funct_i, RSdata_i, RTdata_i, ExtImmd_i, RSdatasrc_i, RTdatasrc_i);
            guard = 0;
            do begin
                stepCycle();
                if (lastExpStall) begin
                    MEM_ALU_result_i = randVal();
                    WB_RegData_i     = randVal();
                end
                guard++;
            end while (lastExpStall && guard < 3 * XLEN);
        end
        idleInputs();
        stepCycle();
        stepCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
